// File: rtl/cic_comp_fir_if.sv
// Sample, coefficient and status bundle for the CIC compensation FIR.
// master: upstream/controller side, slave: the filter itself.
interface cic_comp_fir_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned NUM_TAPS   = 8
);
  localparam int unsigned ADDR_W = $clog2(NUM_TAPS);

  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] fir_in;
  logic                         ready_out;
  logic                         coef_wr_en;
  logic [ADDR_W-1:0]            coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic signed [DATA_WIDTH-1:0] fir_out;
  logic                         valid_out;
  logic                         overflow;
  logic                         underflow;
  logic                         drop_err;
  logic                         clear_err;

  modport master (
    output valid_in, fir_in, coef_wr_en, coef_addr, coef_data, clear_err,
    input  ready_out, fir_out, valid_out, overflow, underflow, drop_err
  );

  modport slave (
    input  valid_in, fir_in, coef_wr_en, coef_addr, coef_data, clear_err,
    output ready_out, fir_out, valid_out, overflow, underflow, drop_err
  );
endinterface

// File: rtl/cic_comp_fir.sv
// Serial-MAC CIC droop compensation FIR with a shadow coefficient bank.
// One multiplier is shared across all taps; a sample takes NUM_TAPS+2 cycles.
// Optional: define CIC_COMP_FIR_SYM_EN for symmetric folding (NUM_TAPS/2 MAC
// cycles, only the lower half of the coefficient bank is writable).
module cic_comp_fir #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_FRAC  = 15,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned COEF_FRAC  = 15,
  parameter int unsigned NUM_TAPS   = 8
) (
  input logic           clk,
  input logic           rst,
  cic_comp_fir_if.slave bus
);
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);
  localparam int unsigned IDX_W     = $clog2(NUM_TAPS);
`ifdef CIC_COMP_FIR_SYM_EN
  localparam int unsigned MAC_LEN = NUM_TAPS / 2;
  localparam int unsigned MUL_A_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MAC_LEN = NUM_TAPS;
  localparam int unsigned MUL_A_W = DATA_WIDTH;
`endif
  localparam int unsigned PROD_W = MUL_A_W + COEF_WIDTH;
  // Products carry DATA_FRAC+COEF_FRAC fraction bits; the output keeps DATA_FRAC.
  localparam int unsigned SHIFT  = (DATA_FRAC + COEF_FRAC) - DATA_FRAC;

  localparam logic [IDX_W-1:0]            LAST_IDX   = IDX_W'(MAC_LEN - 1);
  localparam logic [IDX_W:0]              COEF_SLOTS = (IDX_W + 1)'(MAC_LEN);
  localparam logic signed [COEF_WIDTH-1:0] COEF_UNITY = {1'b0, {(COEF_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  ROUND_BIAS = ACC_WIDTH'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX    =
    ACC_WIDTH'({1'b0, {(DATA_WIDTH - 1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN    = ~SAT_MAX;

  typedef enum logic [1:0] {StIdle, StMac, StRound} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  fir_out_q, fir_out_d;
  logic                          valid_out_q, valid_out_d;
  logic                          ovf_q, ovf_d;
  logic                          unf_q, unf_d;
  logic                          drop_q, drop_d;

  logic signed [DATA_WIDTH-1:0]  x_q  [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  h_q  [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  sh_q [NUM_TAPS];

  logic                          accept;
  logic signed [MUL_A_W-1:0]     mul_a;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]   rnd;

  assign accept = (state_q == StIdle) && bus.valid_in;

`ifdef CIC_COMP_FIR_SYM_EN
  logic [IDX_W-1:0] mir_idx;
  assign mir_idx = IDX_W'(NUM_TAPS - 1) - idx_q;
  // Pre-add mirrored taps one bit wider so the sum cannot wrap.
  assign mul_a = $signed({x_q[idx_q][DATA_WIDTH-1], x_q[idx_q]})
               + $signed({x_q[mir_idx][DATA_WIDTH-1], x_q[mir_idx]});
`else
  assign mul_a = x_q[idx_q];
`endif

  assign prod = $signed({{COEF_WIDTH{mul_a[MUL_A_W-1]}}, mul_a})
              * $signed({{MUL_A_W{h_q[idx_q][COEF_WIDTH-1]}}, h_q[idx_q]});
  assign rnd  = (acc_q + ROUND_BIAS) >>> SHIFT;

  // FSM next state, MAC accumulate, round/saturate and sticky drop flag.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    fir_out_d   = fir_out_q;
    valid_out_d = 1'b0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    drop_d      = drop_q;
    if (bus.clear_err) drop_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          state_d = StMac;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = StRound;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StRound: begin
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
        valid_out_d = 1'b1;
        state_d     = StIdle;
        if (rnd > SAT_MAX) begin
          fir_out_d = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
          ovf_d     = 1'b1;
        end else if (rnd < SAT_MIN) begin
          fir_out_d = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
          unf_d     = 1'b1;
        end else begin
          fir_out_d = rnd[DATA_WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
    // A sample arriving while busy is lost; setting beats clearing.
    if (bus.valid_in && (state_q != StIdle)) drop_d = 1'b1;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= '0;
      fir_out_q   <= '0;
      valid_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      fir_out_q   <= fir_out_d;
      valid_out_q <= valid_out_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      drop_q      <= drop_d;
    end
  end

  // Delay line and coefficient banks; active bank is snapshotted on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k]  <= '0;
        h_q[k]  <= (k == 0) ? COEF_UNITY : '0;
        sh_q[k] <= (k == 0) ? COEF_UNITY : '0;
      end
    end else begin
      if (accept) begin
        x_q[0] <= bus.fir_in;
        for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
        for (int k = 0; k < NUM_TAPS; k++) h_q[k] <= sh_q[k];
      end
      // Shadow write races the snapshot above and lands after it.
      if (bus.coef_wr_en && ({1'b0, bus.coef_addr} < COEF_SLOTS)) begin
        sh_q[bus.coef_addr] <= bus.coef_data;
      end
    end
  end

  assign bus.ready_out = (state_q == StIdle);
  assign bus.fir_out   = fir_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.drop_err  = drop_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir (default, asymmetric build).
module tb_cic_comp_fir;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned NT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cic_comp_fir_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT)) bus ();

  cic_comp_fir #(
    .DATA_WIDTH(DW),
    .DATA_FRAC (15),
    .COEF_WIDTH(CW),
    .COEF_FRAC (15),
    .NUM_TAPS  (NT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int     data;
    bit     ovf;
    bit     unf;
    longint due;
  } exp_t;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   sb[$];
  exp_t   outs[$];
  exp_t   e;
  int     m_x[NT];
  int     m_h[NT];
  int     m_sh[NT];
  int     m_busy;
  bit     m_drop;
  int     m_last;
  bit     m_ovf;
  bit     m_unf;
  longint cyc = 0;
  longint sum;
  longint r;
  int     base;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: acceptance, delay line, coefficient banks, drop flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NT; k++) begin
        m_x[k]  = 0;
        m_h[k]  = (k == 0) ? 32767 : 0;
        m_sh[k] = (k == 0) ? 32767 : 0;
      end
      m_busy = 0;
      m_drop = 0;
      sb.delete();
    end else begin
      cyc++;
      if (bus.clear_err) m_drop = 0;
      if (bus.valid_in && m_busy != 0) m_drop = 1;
      if (bus.valid_in && m_busy == 0) begin
        for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = bus.fir_in;
        for (int k = 0; k < NT; k++) m_h[k] = m_sh[k];
        sum = 0;
        for (int k = 0; k < NT; k++) sum += longint'(m_x[k]) * longint'(m_h[k]);
        r = (sum + 16384) >>> 15;
        if (r > 32767)       sb.push_back('{data: 32767, ovf: 1, unf: 0, due: cyc + NT + 1});
        else if (r < -32768) sb.push_back('{data: -32768, ovf: 0, unf: 1, due: cyc + NT + 1});
        else                 sb.push_back('{data: int'(r), ovf: 0, unf: 0, due: cyc + NT + 1});
        m_busy = NT + 1;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      if (bus.coef_wr_en) m_sh[bus.coef_addr] = bus.coef_data;
    end
  end

  // Monitor: pop on valid_out, and check held outputs every cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_last = 0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid_out", bus.valid_out, 0);
        end else begin
          e = sb.pop_front();
          check_eq("latency", cyc, e.due);
          m_last = e.data;
          m_ovf  = e.ovf;
          m_unf  = e.unf;
          outs.push_back('{data: bus.fir_out, ovf: bus.overflow, unf: bus.underflow, due: cyc});
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        check_eq("missing_valid_out", bus.valid_out, 1);
        void'(sb.pop_front());
      end
      check_eq("fir_out", bus.fir_out, m_last);
      check_eq("overflow", bus.overflow, m_ovf);
      check_eq("underflow", bus.underflow, m_unf);
      check_eq("ready_out", bus.ready_out, m_busy == 0);
      check_eq("drop_err", bus.drop_err, m_drop);
    end
  end

  task automatic send(input int s);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.fir_in   = DW'(s);
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  // Next send after this is accepted exactly NT+2 edges later.
  task automatic send_gap(input int s);
    send(s);
    repeat (NT) @(negedge clk);
  endtask

  task automatic wr_coef(input int a, input int d);
    @(negedge clk);
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = a[$clog2(NT)-1:0];
    bus.coef_data  = CW'(d);
    @(negedge clk);
    bus.coef_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in   = 1'b0;
    bus.fir_in     = '0;
    bus.coef_wr_en = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
    bus.clear_err  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", bus.ready_out, 1);
    check_eq("rst_fir_out", bus.fir_out, 0);
    check_eq("rst_valid", bus.valid_out, 0);
    check_eq("rst_ovf", bus.overflow, 0);
    check_eq("rst_unf", bus.underflow, 0);
    check_eq("rst_drop", bus.drop_err, 0);

    // Impulse response.
    wr_coef(0, 16'h1000);
    wr_coef(1, 16'h2000);
    base = outs.size();
    send_gap(16'h4000);
    for (int i = 0; i < 3; i++) send_gap(0);
    drain();
    check_eq("impulse_count", outs.size(), base + 4);
    if (outs.size() >= base + 4) begin
      check_eq("impulse_0", outs[base].data, 16'h0800);
      check_eq("impulse_1", outs[base+1].data, 16'h1000);
      check_eq("impulse_2", outs[base+2].data, 0);
      check_eq("impulse_3", outs[base+3].data, 0);
    end

    // Positive saturation.
    do_reset();
    for (int k = 0; k < NT; k++) wr_coef(k, 16'h7FFF);
    for (int i = 0; i < NT; i++) send_gap(16'h7FFF);
    drain();
    check_eq("pos_sat_data", outs[$].data, 32767);
    check_eq("pos_sat_ovf", outs[$].ovf, 1);
    check_eq("pos_sat_unf", outs[$].unf, 0);

    // Negative saturation.
    do_reset();
    for (int k = 0; k < NT; k++) wr_coef(k, 16'h7FFF);
    for (int i = 0; i < NT; i++) send_gap(-32768);
    drain();
    check_eq("neg_sat_data", outs[$].data, -32768);
    check_eq("neg_sat_unf", outs[$].unf, 1);
    check_eq("neg_sat_ovf", outs[$].ovf, 0);

    // Drop three cycles after acceptance, then clear, then clear-vs-set.
    do_reset();
    send(16'h4000);
    @(negedge clk);
    send(16'h1234);
    check_eq("drop_set", bus.drop_err, 1);
    drain();
    check_eq("drop_pending_out", outs[$].data, 16'h4000);
    @(negedge clk);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check_eq("drop_cleared", bus.drop_err, 0);
    send(16'h0100);
    bus.valid_in  = 1'b1;
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.clear_err = 1'b0;
    check_eq("drop_set_wins", bus.drop_err, 1);
    drain();

    // Reset in the middle of MAC aborts the sample.
    do_reset();
    base = outs.size();
    send(16'h4000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("abort_no_valid", outs.size(), base);
    send_gap(16'h4000);
    drain();
    check_eq("default_taps", outs[$].data, 16'h4000);

    // Coefficient write during MAC only affects the next sample.
    send(16'h2000);
    repeat (2) @(negedge clk);
    wr_coef(0, 16'h4000);
    drain();
    check_eq("shadow_old", outs[$].data, 16'h2000);
    send(16'h2000);
    drain();
    check_eq("shadow_new", outs[$].data, 16'h1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
